// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encodings, default width and a width helper.
// Pure package with no logic or latency.
// No flow control: the ALU computes a result every cycle.
package alu_pkg;

  // Operation select encodings; the numeric values are the external s codes.
  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_SLL = 3'b101,
    OP_SRL = 3'b110,
    OP_SLT = 3'b111
  } alu_op_e;

  localparam int unsigned ALU_DEF_WIDTH = 32;

  // Width of the shift-amount field taken from the low bits of b.
  // A one-bit datapath still gets a one-bit field so the slice stays legal.
  function automatic int unsigned shamt_bits(input int unsigned w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/alu_if.sv
// Operand/result bundle between the ALU register stage and its datapath.
// Purely combinational wiring, zero latency.
// No backpressure: operands and result are valid every cycle.
interface alu_if #(
  parameter int WIDTH = 32
);

  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0]       s;
  logic [WIDTH-1:0] result;

  // Side that supplies operands and consumes the result.
  modport master (
    output a,
    output b,
    output s,
    input  result
  );

  // Side that computes the result from the operands.
  modport slave (
    input  a,
    input  b,
    input  s,
    output result
  );

endinterface

// File: rtl/alu_core.sv
// Combinational ALU datapath: add/sub, bitwise logic, logical shifts, signed compare.
// Zero latency; the caller registers the result.
// No backpressure; result follows the operands every cycle.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_DEF_WIDTH
) (
  alu_if.slave bus
);

  localparam int SHW = shamt_bits(WIDTH);

  logic [SHW-1:0]   w_shamt;
  logic             w_lt;
  logic [WIDTH-1:0] w_result;

  // Only the low bits of b steer the shifter; upper bits are ignored.
  assign w_shamt = bus.b[SHW-1:0];

  // Two's-complement ordering for the set-less-than operation.
  assign w_lt = ($signed(bus.a) < $signed(bus.b));

  // Operation mux; zero default keeps it latch-free and gives a defined
  // result even for an unknown select.
  always_comb begin
    w_result = '0;
    case (bus.s)
      OP_ADD:  w_result = bus.a + bus.b;
      OP_SUB:  w_result = bus.a - bus.b;
      OP_AND:  w_result = bus.a & bus.b;
      OP_OR:   w_result = bus.a | bus.b;
      OP_XOR:  w_result = bus.a ^ bus.b;
      OP_SLL:  w_result = bus.a << w_shamt;
      OP_SRL:  w_result = bus.a >> w_shamt;
      OP_SLT:  w_result = {{(WIDTH-1){1'b0}}, w_lt};
      default: w_result = '0;
    endcase
  end

  assign bus.result = w_result;

endmodule

// File: rtl/alu.sv
// Registered ALU: out at edge N+1 is the result of a, b, s sampled at edge N.
// One-cycle latency; synchronous active-low rst forces out to zero.
// No handshake or enable: out updates on every clock while out of reset.
module alu
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_DEF_WIDTH
) (
  input  logic             clk,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       s,
  output logic [WIDTH-1:0] out,
  input  logic             rst
);

  logic [WIDTH-1:0] r_out;

  alu_if #(.WIDTH(WIDTH)) w_bus ();

  assign w_bus.a = a;
  assign w_bus.b = b;
  assign w_bus.s = s;

  alu_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .bus(w_bus.slave)
  );

  // Result register; reset wins over any operation and leaves no residue.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_out <= '0;
    end else begin
      r_out <= w_bus.result;
    end
  end

  assign out = r_out;

endmodule

// File: tb/tb_alu.sv
// Testbench for the registered ALU: directed literal cases plus random traffic.
// Expected results come from an arithmetic reference model evaluated at each edge.
// Outputs are compared half a cycle after the edge that produced them.
module tb_alu;

  localparam int W = 32;

  logic clk;
  logic rst;

  int checks;
  int errors;

  logic [W-1:0] m_exp;
  logic         m_vld;

  alu_if #(.WIDTH(W)) u_bus ();

  alu #(
    .WIDTH(W)
  ) dut (
    .clk(clk),
    .a  (u_bus.a),
    .b  (u_bus.b),
    .s  (u_bus.s),
    .out(u_bus.result),
    .rst(rst)
  );

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model built from plain integer arithmetic on 64-bit values.
  function automatic logic [W-1:0] ref_alu(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic [2:0] op);
    longint unsigned ux;
    longint unsigned uy;
    longint unsigned m;
    longint          sx;
    longint          sy;
    int              sh;
    ux = longint'(x);
    uy = longint'(y);
    m  = 64'h1_0000_0000;
    sx = x[W-1] ? longint'(ux) - longint'(m) : longint'(ux);
    sy = y[W-1] ? longint'(uy) - longint'(m) : longint'(uy);
    sh = int'(uy % 64'd32);
    case (op)
      3'd0:    return W'((ux + uy) % m);
      3'd1:    return W'((ux + m - uy) % m);
      3'd2:    return x & y;
      3'd3:    return x | y;
      3'd4:    return x ^ y;
      3'd5:    return W'((ux * (64'd1 << sh)) % m);
      3'd6:    return W'(ux / (64'd1 << sh));
      3'd7:    return (sx < sy) ? W'(1) : W'(0);
      default: return '0;
    endcase
  endfunction

  task automatic check(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h at time %0t", nm, act, exp, $time);
    end
  endtask

  // Model snapshot at every rising edge: what out must become at this edge.
  always @(posedge clk) begin
    m_exp = rst ? ref_alu(u_bus.a, u_bus.b, u_bus.s) : '0;
    m_vld = 1'b1;
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (m_vld) check("model", u_bus.result, m_exp);
  end

  // Directed case: apply inputs, let one edge pass, check a literal result.
  task automatic apply_chk(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                           input logic [2:0] ts, input logic tr,
                           input logic [W-1:0] lit, input string nm);
    @(negedge clk);
    u_bus.a = ta;
    u_bus.b = tb_v;
    u_bus.s = ts;
    rst     = tr;
    @(posedge clk);
    #1;
    check(nm, u_bus.result, lit);
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 7))
      0:       return '0;
      1:       return '1;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      4:       return W'($urandom_range(0, 40));
      default: return W'($urandom);
    endcase
  endfunction

  // Watchdog so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

  // Stimulus sequence.
  initial begin
    checks  = 0;
    errors  = 0;
    m_vld   = 1'b0;
    m_exp   = '0;
    rst     = 1'b0;
    u_bus.a = 32'h5F;
    u_bus.b = 32'h0A;
    u_bus.s = 3'b000;

    // Reset state and hold with live operands present.
    apply_chk(32'h5F, 32'h0A, 3'b000, 1'b0, 32'h0, "reset_0");
    apply_chk(32'hFFFF_FFFF, 32'h1, 3'b011, 1'b0, 32'h0, "reset_1");

    // First edge out of reset already produces a result.
    apply_chk(32'h5F, 32'h0A, 3'b000, 1'b1, 32'h69, "add");
    apply_chk(32'h5F, 32'h0A, 3'b001, 1'b1, 32'h55, "sub");
    apply_chk(32'h5F, 32'h0A, 3'b010, 1'b1, 32'h0A, "and");
    apply_chk(32'h5F, 32'h0A, 3'b011, 1'b1, 32'h5F, "or");
    apply_chk(32'h5F, 32'h0A, 3'b100, 1'b1, 32'h55, "xor");
    apply_chk(32'h5F, 32'h0A, 3'b101, 1'b1, 32'h0001_7C00, "sll");
    apply_chk(32'h5F, 32'h0A, 3'b110, 1'b1, 32'h0, "srl");
    apply_chk(32'h5F, 32'h0A, 3'b111, 1'b1, 32'h0, "slt");
    apply_chk(32'hFFFF_FFFF, 32'h1, 3'b000, 1'b1, 32'h0, "add_wrap");
    apply_chk(32'h0, 32'h1, 3'b001, 1'b1, 32'hFFFF_FFFF, "sub_wrap");
    apply_chk(32'h8000_0000, 32'h1, 3'b111, 1'b1, 32'h1, "slt_neg");
    apply_chk(32'h1, 32'h8000_0000, 3'b111, 1'b1, 32'h0, "slt_swap");
    apply_chk(32'h1, 32'hFFFF_FFE4, 3'b101, 1'b1, 32'h10, "sll_hi_b");
    apply_chk(32'hA5A5_1234, 32'h20, 3'b101, 1'b1, 32'hA5A5_1234, "sll_zero");
    apply_chk(32'h8000_0000, 32'h1F, 3'b110, 1'b1, 32'h1, "srl_31");

    // Mid-stream reset discards the in-flight result and holds zero.
    apply_chk(32'h1234_5678, 32'h1111_1111, 3'b000, 1'b1, 32'h2345_6789, "pre_rst");
    apply_chk(32'h1234_5678, 32'h1111_1111, 3'b011, 1'b0, 32'h0, "mid_rst_0");
    apply_chk(32'hDEAD_BEEF, 32'h0000_FFFF, 3'b100, 1'b0, 32'h0, "mid_rst_1");
    apply_chk(32'hDEAD_BEEF, 32'h0000_FFFF, 3'b010, 1'b1, 32'h0000_BEEF, "post_rst");

    // Random traffic with occasional reset pulses, checked by the model.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      rst     = ($urandom_range(0, 15) != 0);
      u_bus.a = pick();
      u_bus.b = pick();
      u_bus.s = 3'($urandom_range(0, 7));
    end

    @(negedge clk);
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu.md
ALU -- requirements
Module: alu

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data width of operands and result.
REQ-002 SHALL have port clk, input, 1, rising-edge clock for all state.
REQ-003 SHALL have port rst, input, 1, reset; one clock, reset synchronous and active-low.
REQ-004 SHALL have port a, input, WIDTH, operand A.
REQ-005 SHALL have port b, input, WIDTH, operand B; b[$clog2(WIDTH)-1:0] is the shift amount for shift ops.
REQ-006 SHALL have port s, input, 3, operation select.
REQ-007 SHALL have port out, output, WIDTH, registered result.
REQ-008 SHALL keep the port order clk, a, b, s, out, rst for positional instantiation.

Function
REQ-009 SHALL register the result: out at edge N+1 reflects a, b and s sampled at edge N, giving 1-cycle latency with no handshake.
REQ-010 SHALL, for s=000, compute a+b modulo 2^WIDTH, with carry discarded.
REQ-011 SHALL, for s=001, compute a-b modulo 2^WIDTH, two's-complement wrap.
REQ-012 SHALL, for s=010, compute bitwise a AND b.
REQ-013 SHALL, for s=011, compute bitwise a OR b.
REQ-014 SHALL, for s=100, compute bitwise a XOR b.
REQ-015 SHALL, for s=101, compute logical left shift of a by the shift amount, zero fill.
REQ-016 SHALL, for s=110, compute logical right shift of a by the shift amount, zero fill.
REQ-017 SHALL, for s=111, output 1 (zero-extended) if signed(a) < signed(b), else 0.
REQ-018 SHALL ignore b bits above the shift-amount field for shift ops; a shift of 0 SHALL return a unchanged.
REQ-019 SHALL update out every cycle while rst=1, with no enable and no hold.
REQ-020 SHALL be fully defined for every s value, with no X propagation from s.

Reset
REQ-021 SHALL clear out to 0 at any rising clk edge where rst=0, overriding any operation.
REQ-022 SHALL hold out at 0 for as long as rst stays 0.
REQ-023 SHALL produce, on the first edge after rst returns to 1, the result of the inputs sampled at that edge.
REQ-024 SHALL, when rst is asserted mid-stream, discard the in-flight result, with no residual state.

Structure
REQ-025 SHALL place the opcode encodings (ADD, SUB, AND, OR, XOR, SLL, SRL, SLT) as a typedef enum in shared package alu_pkg.
REQ-026 SHALL use one combinational sub-module, alu_core (a, b, s -> result), plus the output register in alu.
REQ-027 SHALL avoid latches; the case default SHALL drive 0.

Verification (a=0x5F, b=0x0A, rst=1, results checked one edge after apply)
REQ-028 Apply s=000..100 in sequence -> out = 0x69, 0x55, 0x0A, 0x5F, 0x55.
REQ-029 Apply s=101 -> out 0x00017C00; apply s=110 -> out 0x00000000; apply s=111 -> out 0x00000000.
REQ-030 Apply a=0xFFFFFFFF, b=1, s=000 -> out 0x00000000; then a=0, b=1, s=001 -> out 0xFFFFFFFF.
REQ-031 Apply a=0x80000000, b=0x00000001, s=111 -> out 1; swap a and b -> out 0.
REQ-032 Apply a=0x1, b=0xFFFFFFE4, s=101 -> shift by 4 -> out 0x10.
REQ-033 Drive rst=0 mid-sequence -> out 0 at the next edge and held; release rst -> valid result one edge later.
